// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-and-add multiplier: one operand pair in, exact N+M bit product
// out after M add/shift steps, with valid/ready handshakes on both sides.
module shift_add_multiplier #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     multiplicand,
  input  logic [M-1:0]     multiplier,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N+M-1:0]   product
);

  localparam int unsigned PW = N + M;
  localparam int unsigned CW = $clog2(M + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_sh_q, mcand_sh_d;
  logic [M-1:0]    mplier_sh_q, mplier_sh_d;
  logic [CW-1:0]   count_q, count_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_sh_q  <= '0;
      mplier_sh_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_sh_q  <= mcand_sh_d;
      mplier_sh_q <= mplier_sh_d;
      count_q     <= count_d;
    end
  end

  // Next-state and datapath step; exactly M steps regardless of operand values
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_sh_d  = mcand_sh_q;
    mplier_sh_d = mplier_sh_q;
    count_d     = count_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d       = '0;
          mcand_sh_d  = PW'(multiplicand);
          mplier_sh_d = multiplier;
          count_d     = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (mplier_sh_q[0]) begin
          acc_d = acc_q + mcand_sh_q;
        end
        mcand_sh_d  = mcand_sh_q << 1;
        mplier_sh_d = mplier_sh_q >> 1;
        count_d     = count_q + CW'(1);
        if (count_q == CW'(M - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = acc_q;

endmodule
